// File: rtl/unum_mul_arbiter_if.sv
// Requester, multiplier and control bundle for unum_mul_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface unum_mul_arbiter_if #(
  parameter int unsigned W       = 32,
  parameter int unsigned MUL_LAT = 4
);
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 2) + 1;

  logic             req0_valid;
  logic [W-1:0]     req0_a;
  logic [W-1:0]     req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [W-1:0]     req1_a;
  logic [W-1:0]     req1_b;
  logic             req1_ready;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [W-1:0]     mul_o;
  logic             mul_nan;
  logic             rsp_valid;
  logic             rsp_id;
  logic [W-1:0]     rsp_unum;
  logic             rsp_nan;
  logic             drain;
  logic             drain_done;
  logic [CNT_W-1:0] inflight;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  mul_o, mul_nan, drain,
    output req0_ready, req1_ready, mul_a, mul_b,
    output rsp_valid, rsp_id, rsp_unum, rsp_nan, drain_done, inflight
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output mul_o, mul_nan, drain,
    input  req0_ready, req1_ready, mul_a, mul_b,
    input  rsp_valid, rsp_id, rsp_unum, rsp_nan, drain_done, inflight
  );
endinterface

// File: rtl/unum_mul_arbiter.sv
// Round-robin share of one pipelined unum multiplier between two requesters,
// with an ID tag pipe for response routing and a drain/halt quiesce FSM.
module unum_mul_arbiter #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  unum_mul_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 2) + 1;
  localparam int unsigned TAG_D = MUL_LAT + 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic [TAG_D-1:0] tag_v;
  logic [TAG_D-1:0] tag_id;
  logic [CNT_W-1:0] inflight_q;
  logic             issue_ok_c;
  logic             grant0_c;
  logic             grant1_c;
  logic             accept_c;
  logic             retire_c;

  // Issue is blocked as soon as drain is seen, so the drain edge never accepts.
  assign issue_ok_c = (state == ST_RUN) && !bus.drain;
  assign grant0_c   = issue_ok_c && bus.req0_valid && (!bus.req1_valid || last_grant);
  assign grant1_c   = issue_ok_c && bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign accept_c   = grant0_c || grant1_c;
  assign retire_c   = tag_v[MUL_LAT];

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;
  assign bus.inflight   = inflight_q;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (bus.drain)             state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight_q == '0)      state_nxt = ST_HALT;
      ST_HALT:  if (!bus.drain)            state_nxt = ST_RUN;
      default:                             state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand issue, tag pipe, response capture and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant     <= 1'b1;
      bus.mul_a      <= W'(0);
      bus.mul_b      <= W'(0);
      tag_v          <= '0;
      tag_id         <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_unum   <= W'(0);
      bus.rsp_nan    <= 1'b0;
      bus.drain_done <= 1'b0;
      inflight_q     <= '0;
    end else begin
      if (accept_c) begin
        last_grant <= grant1_c;
      end
      // Idle cycles feed 0x0 so the multiplier does not toggle needlessly.
      bus.mul_a <= grant0_c ? bus.req0_a : (grant1_c ? bus.req1_a : W'(0));
      bus.mul_b <= grant0_c ? bus.req0_b : (grant1_c ? bus.req1_b : W'(0));
      tag_v     <= {tag_v[TAG_D-2:0], accept_c};
      tag_id    <= {tag_id[TAG_D-2:0], grant1_c};

      bus.rsp_valid <= retire_c;
      if (retire_c) begin
        bus.rsp_id   <= tag_id[MUL_LAT];
        bus.rsp_unum <= bus.mul_o;
        bus.rsp_nan  <= bus.mul_nan;
      end

      bus.drain_done <= (state_nxt == ST_HALT);

      case ({accept_c, retire_c})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end
endmodule

// File: tb/tb_unum_mul_arbiter.sv
// Directed bench for unum_mul_arbiter: behavioural fixed-latency multiplier,
// scoreboard of expected responses keyed by due cycle.
module tb_unum_mul_arbiter;
  localparam int MUL_LAT = 4;
  localparam int W       = 32;

  typedef struct {
    logic        id;
    logic [31:0] unum;
    logic        nan;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];

  unum_mul_arbiter_if #(.W(W), .MUL_LAT(MUL_LAT)) bus ();

  unum_mul_arbiter #(.MUL_LAT(MUL_LAT), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Known unum products for the directed vectors; anything else gets a
  // distinctive but deterministic value.
  function automatic logic [32:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h55e00000 && b == 32'hbb666666) return {1'b0, 32'ha53e6666};
    if (a == 32'h55e00000 && b == 32'h38cccccd) return {1'b0, 32'h4f0ccccd};
    if (a == 32'hb5800000 && b == 32'h4b800000) return {1'b0, 32'ha9e80000};
    if (a == 32'h55e00000 && b == 32'h80000000) return {1'b1, 32'h80000000};
    if (a == 32'h0 && b == 32'h0)               return 33'd0;
    return {1'b0, a ^ {b[15:0], b[31:16]}};
  endfunction

  // Multiplier model: operands set at edge k give a result stable after k+MUL_LAT.
  logic [32:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_ref(bus.mul_a, bus.mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_o   = mpipe[MUL_LAT-1][31:0];
  assign bus.mul_nan = mpipe[MUL_LAT-1][32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
      chk("rsp_unum", 64'(bus.rsp_unum), 64'(e.unum));
      chk("rsp_nan", 64'(bus.rsp_nan), 64'(e.nan));
    end else begin
      chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
    end
    chk("inflight", 64'(bus.inflight), 64'(q.size()));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_rsp();
  endtask

  task automatic push(input logic id, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = mul_ref(a, b);
    q.push_back('{id: id, unum: r[31:0], nan: r[32], due: cyc + MUL_LAT + 2});
  endtask

  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic er0, input logic er1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    #1;
    chk("req0_ready", 64'(bus.req0_ready), 64'(er0));
    chk("req1_ready", 64'(bus.req1_ready), 64'(er1));
    if (er0) push(1'b0, a0, b0);
    if (er1) push(1'b1, a1, b1);
    tick();
    chk("mul_a", 64'(bus.mul_a), 64'(er0 ? a0 : (er1 ? a1 : 32'h0)));
    chk("mul_b", 64'(bus.mul_b), 64'(er0 ? b0 : (er1 ? b1 : 32'h0)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    #1;
    chk("rst_mul_a", 64'(bus.mul_a), 64'(0));
    chk("rst_mul_b", 64'(bus.mul_b), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_inflight", 64'(bus.inflight), 64'(0));
    chk("rst_drain_done", 64'(bus.drain_done), 64'(0));
    tick();
    tick();
    rst = 1'b0;
  endtask

  int x;

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.drain = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_rsp_unum", 64'(bus.rsp_unum), 64'(0));
    chk("rst_rsp_nan", 64'(bus.rsp_nan), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));

    // Single request, response MUL_LAT+1 edges after acceptance.
    step(1'b1, 32'hb5800000, 32'h4b800000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(7);

    // Contention from reset: strict alternation starting with requester 0.
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h55e00000, 32'h38cccccd, 1'b1, 32'h55e00000, 32'hbb666666,
           (i % 2) == 0, (i % 2) == 1);
    idle(7);

    // NaN passthrough, then a clean zero product.
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h55e00000, 32'h80000000, 1'b0, 1'b1);
    step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(7);

    // Drain: three accepts, then quiesce with both requesters still pushing.
    step(1'b1, 32'h12345678, 32'h0badf00d, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'hcafe0001, 32'h00c0ffee, 1'b0, 1'b1);
    step(1'b1, 32'h7f001234, 32'h11112222, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    x = cyc;
    bus.drain = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'h1, 32'h2, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
      chk("drain_done", 64'(bus.drain_done), 64'(cyc >= x + 6));
    end
    bus.drain = 1'b0;
    step(1'b1, 32'h1, 32'h2, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
    chk("drain_done_exit", 64'(bus.drain_done), 64'(0));
    step(1'b1, 32'h1, 32'h2, 1'b1, 32'h3, 32'h4, 1'b0, 1'b1);
    idle(7);

    // Reset with two products in flight: they must vanish.
    step(1'b1, 32'haaaa5555, 32'h01010101, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h5555aaaa, 32'h02020202, 1'b0, 1'b1);
    idle(1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    do_reset();
    idle(8);
    step(1'b1, 32'h55e00000, 32'h38cccccd, 1'b1, 32'h55e00000, 32'hbb666666, 1'b1, 1'b0);
    idle(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
